// File: rtl/accel_pkg.sv
// Shared constants for the accelerometer axis filter: axis codes, sample width
// and default filter parameters.
package accel_pkg;

  typedef enum logic [1:0] {
    AXIS_X    = 2'd0,
    AXIS_Y    = 2'd1,
    AXIS_Z    = 2'd2,
    AXIS_RSVD = 2'd3
  } axis_e;

  localparam int unsigned SAMPLE_W        = 8;
  localparam int unsigned AVG_LOG2_DEF    = 2;
  localparam int          TILT_THRESH_DEF = 32;

endpackage

// File: rtl/accel_avg_lane.sv
// One axis lane: an N-deep sample buffer with a running sum, producing a
// registered moving average (floor of sum / N) and a sticky window-full flag.
module accel_avg_lane
  import accel_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                WR_EN,
  input  logic [SAMPLE_W-1:0] SAMPLE,
  output logic [SAMPLE_W-1:0] AVG,
  output logic                FULL
);

  localparam int unsigned N    = 1 << AVG_LOG2;
  localparam int unsigned SumW = SAMPLE_W + AVG_LOG2;
  localparam logic [AVG_LOG2:0] FillMax = (AVG_LOG2 + 1)'(N);

  logic [SAMPLE_W-1:0] mem_q [N];
  logic [AVG_LOG2-1:0] wptr_q;
  logic [AVG_LOG2:0]   fill_q, fill_d;
  logic [SumW-1:0]     sum_q, sum_d;
  logic [SAMPLE_W-1:0] avg_q;
  logic                full_q;
  logic [SAMPLE_W-1:0] oldest;

  // Next running sum: add the new sample, drop the one it overwrites.
  always_comb begin
    oldest = mem_q[wptr_q];
    sum_d  = sum_q + {{AVG_LOG2{SAMPLE[SAMPLE_W-1]}}, SAMPLE}
                   - {{AVG_LOG2{oldest[SAMPLE_W-1]}}, oldest};
    fill_d = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
  end

  // Lane state; the top bits of the sum are the arithmetic-shifted (floored) average.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < int'(N); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      fill_q <= '0;
      sum_q  <= '0;
      avg_q  <= '0;
      full_q <= 1'b0;
    end else if (WR_EN) begin
      mem_q[wptr_q] <= SAMPLE;
      wptr_q        <= wptr_q + 1'b1;
      fill_q        <= fill_d;
      sum_q         <= sum_d;
      avg_q         <= sum_d[SumW-1:AVG_LOG2];
      full_q        <= (fill_d == FillMax);
    end
  end

  assign AVG  = avg_q;
  assign FULL = full_q;

endmodule

// File: rtl/accel_axis_filter.sv
// Per-axis moving-average filter for accelerometer bytes from the SPI
// controller. Optional tilt flags are built when TILT_DETECT_EN is defined.
module accel_axis_filter
  import accel_pkg::*;
#(
  parameter int unsigned AVG_LOG2 = AVG_LOG2_DEF
`ifdef TILT_DETECT_EN
  , parameter int TILT_THRESH = TILT_THRESH_DEF
`endif
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [SAMPLE_W-1:0] DATA_IN,
  input  logic                DATA_VALID,
  input  logic [1:0]          AXIS_SEL,
  output logic [SAMPLE_W-1:0] X_AVG,
  output logic [SAMPLE_W-1:0] Y_AVG,
  output logic [SAMPLE_W-1:0] Z_AVG,
  output logic [2:0]          FULL,
  output logic                AVG_VALID,
  output logic [1:0]          AVG_AXIS
`ifdef TILT_DETECT_EN
  , output logic [5:0]        TILT
`endif
);

  logic                accept;
  logic [2:0]          wr_en;
  logic [SAMPLE_W-1:0] avg [3];
  logic                avg_valid_q;
  logic [1:0]          avg_axis_q;

  // Decode the axis tag into a one-hot lane write enable; reserved code is dropped.
  always_comb begin
    accept = 1'b0;
    wr_en  = '0;
    if (DATA_VALID) begin
      unique case (AXIS_SEL)
        AXIS_X:  begin accept = 1'b1; wr_en[0] = 1'b1; end
        AXIS_Y:  begin accept = 1'b1; wr_en[1] = 1'b1; end
        AXIS_Z:  begin accept = 1'b1; wr_en[2] = 1'b1; end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_lane
    accel_avg_lane #(
      .AVG_LOG2(AVG_LOG2)
    ) u_lane (
      .CLK   (CLK),
      .RESET (RESET),
      .WR_EN (wr_en[g]),
      .SAMPLE(DATA_IN),
      .AVG   (avg[g]),
      .FULL  (FULL[g])
    );
  end

  // Update strobe, aligned with the lane average registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      avg_valid_q <= 1'b0;
      avg_axis_q  <= '0;
    end else begin
      avg_valid_q <= accept;
      if (accept) avg_axis_q <= AXIS_SEL;
    end
  end

  assign X_AVG     = avg[0];
  assign Y_AVG     = avg[1];
  assign Z_AVG     = avg[2];
  assign AVG_VALID = avg_valid_q;
  assign AVG_AXIS  = avg_axis_q;

`ifdef TILT_DETECT_EN
  localparam logic signed [SAMPLE_W-1:0] ThrPos = SAMPLE_W'(TILT_THRESH);
  localparam logic signed [SAMPLE_W-1:0] ThrNeg = SAMPLE_W'(-TILT_THRESH);

  // Tilt flags follow the registered averages, so they change in the same cycle.
  always_comb begin
    TILT = '0;
    for (int a = 0; a < 3; a++) begin
      TILT[2*a]   = FULL[a] && ($signed(avg[a]) > ThrPos);
      TILT[2*a+1] = FULL[a] && ($signed(avg[a]) < ThrNeg);
    end
  end
`endif

endmodule

// File: tb/tb_accel_axis_filter.sv
// Bench for accel_axis_filter: a sliding-window reference model compared
// every cycle, plus directed literal checks and a randomized phase.
module tb_accel_axis_filter;

  localparam int AvgLog2 = 2;
  localparam int N       = 1 << AvgLog2;
  localparam int Thr     = 32;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] DATA_IN = '0;
  logic       DATA_VALID = 1'b0;
  logic [1:0] AXIS_SEL = '0;
  logic [7:0] x_avg, y_avg, z_avg;
  logic [2:0] full;
  logic       avg_valid;
  logic [1:0] avg_axis;
`ifdef TILT_DETECT_EN
  logic [5:0] tilt;
`endif

  accel_axis_filter #(
    .AVG_LOG2(AvgLog2)
`ifdef TILT_DETECT_EN
    , .TILT_THRESH(Thr)
`endif
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DATA_IN   (DATA_IN),
    .DATA_VALID(DATA_VALID),
    .AXIS_SEL  (AXIS_SEL),
    .X_AVG     (x_avg),
    .Y_AVG     (y_avg),
    .Z_AVG     (z_avg),
    .FULL      (full),
    .AVG_VALID (avg_valid),
    .AVG_AXIS  (avg_axis)
`ifdef TILT_DETECT_EN
    , .TILT    (tilt)
`endif
  );

  always #4 CLK = ~CLK;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int floor_div(input int s, input int d);
    int q;
    q = s / d;
    if ((s % d != 0) && (s < 0)) q -= 1;
    return q;
  endfunction

  // Reference model: last N samples per axis, missing entries count as zero.
  int hist [3][$];
  int cnt [3];
  int exp_avg [3];
  bit exp_full [3];
  bit exp_valid;
  int exp_axis;

  always @(posedge CLK) begin
    if (RESET) begin
      for (int a = 0; a < 3; a++) begin
        hist[a].delete();
        cnt[a]      = 0;
        exp_avg[a]  = 0;
        exp_full[a] = 1'b0;
      end
      exp_valid = 1'b0;
      exp_axis  = 0;
    end else begin
      exp_valid = DATA_VALID && (AXIS_SEL != 2'd3);
      if (exp_valid) begin
        int a, s;
        a = int'(AXIS_SEL);
        hist[a].push_back(int'($signed(DATA_IN)));
        if (hist[a].size() > N) void'(hist[a].pop_front());
        s = 0;
        foreach (hist[a][i]) s += hist[a][i];
        exp_avg[a] = floor_div(s, N);
        if (cnt[a] < N) cnt[a]++;
        exp_full[a] = (cnt[a] == N);
        exp_axis    = a;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      check("x_avg", x_avg, 8'(exp_avg[0]));
      check("y_avg", y_avg, 8'(exp_avg[1]));
      check("z_avg", z_avg, 8'(exp_avg[2]));
      check("full", {5'd0, full}, {5'd0, exp_full[2], exp_full[1], exp_full[0]});
      check("avg_valid", {7'd0, avg_valid}, {7'd0, exp_valid});
      if (exp_valid) check("avg_axis", {6'd0, avg_axis}, 8'(exp_axis));
`ifdef TILT_DETECT_EN
      begin
        logic [5:0] et;
        for (int a = 0; a < 3; a++) begin
          et[2*a]   = exp_full[a] && (exp_avg[a] > Thr);
          et[2*a+1] = exp_full[a] && (exp_avg[a] < -Thr);
        end
        check("tilt", {2'd0, tilt}, {2'd0, et});
      end
`endif
    end
  end

  // Present one sample for exactly one clock; returns #1 after the capturing edge.
  task automatic drive(input logic [1:0] ax, input logic [7:0] d);
    DATA_VALID = 1'b1;
    AXIS_SEL   = ax;
    DATA_IN    = d;
    @(posedge CLK);
    #1;
    DATA_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  initial begin
    int pulses;
    logic [7:0] xs [4];
    logic [7:0] xe [4];
    xs[0] = 8'd4;  xs[1] = 8'd8;  xs[2] = 8'd12; xs[3] = 8'd16;
    xe[0] = 8'd1;  xe[1] = 8'd3;  xe[2] = 8'd6;  xe[3] = 8'd10;

    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_x", x_avg, 8'd0);
    check("rst_full", {5'd0, full}, 8'd0);
    check("rst_valid", {7'd0, avg_valid}, 8'd0);
    check("rst_axis", {6'd0, avg_axis}, 8'd0);

    // Warm-up ramp on X
    for (int i = 0; i < 4; i++) begin
      drive(2'd0, xs[i]);
      check("ramp_x", x_avg, xe[i]);
      check("ramp_valid", {7'd0, avg_valid}, 8'd1);
      check("ramp_axis", {6'd0, avg_axis}, 8'd0);
      check("ramp_full", {7'd0, full[0]}, (i == 3) ? 8'd1 : 8'd0);
    end
    idle(1);
    check("idle_valid", {7'd0, avg_valid}, 8'd0);

    // Eviction of oldest sample
    drive(2'd0, 8'd20);
    check("evict_x", x_avg, 8'd14);
    check("evict_y", y_avg, 8'd0);
    check("evict_z", z_avg, 8'd0);

    // Most negative window, then floor of small negative sum
    repeat (4) drive(2'd2, 8'h80);
    check("zmin", z_avg, 8'h80);
    check("zfull", {7'd0, full[2]}, 8'd1);
    drive(2'd1, 8'hFF);
    check("yneg1", y_avg, 8'hFF);
    repeat (3) begin
      drive(2'd1, 8'h00);
      check("yneg", y_avg, 8'hFF);
    end

    // Back-to-back across axes plus a reserved-code sample
    idle(1);
    pulses = 0;
    DATA_VALID = 1'b1;
    AXIS_SEL = 2'd0; DATA_IN = 8'd40;       @(posedge CLK); #1; pulses += int'(avg_valid);
    AXIS_SEL = 2'd1; DATA_IN = 8'(-40);     @(posedge CLK); #1; pulses += int'(avg_valid);
    AXIS_SEL = 2'd2; DATA_IN = 8'd40;       @(posedge CLK); #1; pulses += int'(avg_valid);
    AXIS_SEL = 2'd3; DATA_IN = 8'd99;       @(posedge CLK); #1; pulses += int'(avg_valid);
    DATA_VALID = 1'b0;
    @(posedge CLK); #1; pulses += int'(avg_valid);
    check("b2b_pulses", 8'(pulses), 8'd3);

    // Mid-stream reset discards history
    drive(2'd0, 8'd50);
    drive(2'd0, 8'd60);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("mrst_x", x_avg, 8'd0);
    check("mrst_full", {5'd0, full}, 8'd0);
    drive(2'd0, 8'd8);
    check("mrst_x8", x_avg, 8'd2);

`ifdef TILT_DETECT_EN
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    repeat (3) drive(2'd0, 8'd100);
    check("tilt_pre", {2'd0, tilt}, 8'd0);
    drive(2'd0, 8'd100);
    check("tilt_xp", {2'd0, tilt}, 8'h01);
    repeat (4) drive(2'd1, 8'(-100));
    check("tilt_yn", {2'd0, tilt}, 8'h09);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      RESET      = ($urandom_range(0, 199) == 0);
      DATA_VALID = ($urandom_range(0, 9) < 7);
      AXIS_SEL   = 2'($urandom_range(0, 3));
      DATA_IN    = 8'($urandom);
      @(posedge CLK);
      #1;
    end
    RESET = 1'b0;
    DATA_VALID = 1'b0;
    idle(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/accel_axis_filter.md
Name: accel_axis_filter

Overview:
- Sits directly downstream of the ACL2 SPI controller.
- Consumes each received accelerometer byte, tagged with the axis it belongs to (X, Y, Z), and keeps a per-axis moving average over the last 2^AVG_LOG2 samples.
- Presents filtered signed 8-bit X/Y/Z values plus per-axis "window full" flags to the board-level display/LED logic.

Parameters:
- AVG_LOG2, 2, log2 of the averaging window depth N (legal 1..4; N = 2, 4, 8, 16).
- TILT_THRESH, 32, signed 8-bit magnitude threshold for tilt flags; used only with TILT_DETECT_EN.

Ports:
- CLK  in  1  system clock, 125 MHz.
- RESET  in  1  synchronous, active-high reset.
- DATA_IN  in  8  two's-complement sample byte from the SPI controller.
- DATA_VALID  in  1  single-cycle strobe; DATA_IN and AXIS_SEL are valid in this cycle.
- AXIS_SEL  in  2  axis of the sample: 0=X, 1=Y, 2=Z, 3=reserved.
- X_AVG  out  8  signed moving average, X axis.
- Y_AVG  out  8  signed moving average, Y axis.
- Z_AVG  out  8  signed moving average, Z axis.
- FULL  out  3  per-axis window-full flags, bit0=X, bit1=Y, bit2=Z.
- AVG_VALID  out  1  one-cycle pulse when any *_AVG register updates.
- AVG_AXIS  out  2  axis code of the update; meaningful only while AVG_VALID=1.
- TILT  out  6  {Z-,Z+,Y-,Y+,X-,X+}; present only with TILT_DETECT_EN.

Behaviour:
- Reset, synchronous, with highest priority:
  - All sample buffers, sums, write pointers and fill counters clear to 0.
  - X_AVG/Y_AVG/Z_AVG=0, FULL=0, AVG_VALID=0, AVG_AXIS=0, TILT=0.
  - Reset mid-stream discards all history; the next valid sample is treated as the first.
- Per axis lane state:
  - N x 8-bit register buffer.
  - Write pointer, AVG_LOG2 bits, wraps N-1 -> 0.
  - Fill counter, saturates at N.
  - Signed sum of width 8+AVG_LOG2.
- Accept: DATA_VALID=1 and AXIS_SEL in 0..2.
- On accept, the selected lane only does the following in one cycle:
  - sum <= sum + sext(DATA_IN) - sext(buf[wptr]).
  - buf[wptr] <= DATA_IN.
  - wptr <= wptr+1 (modulo N).
  - Fill counter increments until N.
- Output update, one cycle after the accepting cycle:
  - The lane's *_AVG register takes new_sum >>> AVG_LOG2 (arithmetic shift, floor toward minus infinity).
  - AVG_VALID=1 for one cycle with AVG_AXIS = that axis.
- Zero-seeded warm-up: before the window is full, the buffer holds zeros, so the average ramps up from 0.
- FULL[axis] rises in the same cycle as the AVG update of the Nth accepted sample and stays high until reset.
- Overflow: none possible; the sum range is exactly -128*N..127*N.
- Back-to-back: DATA_VALID may be high every cycle, on the same or different axes. Every sample is accepted, and AVG_VALID then pulses every cycle.
- AXIS_SEL=3 with DATA_VALID=1: ignored. No state change, no AVG_VALID.
- Unselected lanes hold their values.
- There is no backpressure; the block is always ready.

Optional Feature:
- Macro: TILT_DETECT_EN.
- Defined:
  - TILT register updates in the same cycle as the averages.
  - X+ = (X_AVG > TILT_THRESH), X- = (X_AVG < -TILT_THRESH); likewise for Y and Z.
  - Comparisons are signed.
  - Flags are gated by the corresponding FULL bit.
- Undefined:
  - The TILT port and its logic are absent.
  - All other behaviour is identical.

Decomposition:
- Package accel_pkg:
  - Axis codes AXIS_X=0, AXIS_Y=1, AXIS_Z=2, AXIS_RSVD=3.
  - SAMPLE_W=8.
  - Default AVG_LOG2 and TILT_THRESH.
- Sub-module accel_avg_lane, instantiated 3 times:
  - Contains the buffer, pointer, fill counter and sum.
  - Ports: CLK, RESET, WR_EN, SAMPLE, AVG, FULL.
- The top level does AXIS_SEL decode, AVG_VALID/AVG_AXIS registration and optional tilt.

Test Plan (AVG_LOG2=2):
- X samples 4, 8, 12, 16 -> X_AVG = 1, 3, 6, 10. FULL[0] rises with the 4th. Each update carries AVG_VALID with AVG_AXIS=0.
- Then X sample 20 -> X_AVG=14 (oldest sample 4 evicted). Y_AVG and Z_AVG remain 0.
- Z samples -128 x4 -> Z_AVG=-128. Then Y samples -1, 0, 0, 0 -> Y_AVG=-1 after each (arithmetic floor).
- Consecutive-cycle valids X=40, Y=-40, Z=40, AXIS_SEL=3 (value 99) -> exactly three AVG_VALID pulses with axes 0, 1, 2. The reserved-code sample has no effect.
- RESET asserted after 2 X samples -> all outputs 0, FULL=0. The next X sample 8 gives X_AVG=2.
- TILT_DETECT_EN, X samples 100 x4 -> TILT[0]=1 only after FULL[0]. Then Y samples -100 x4 -> TILT[3]=1.
